// File: rtl/timer_mc_pkg.sv
// Shared constants and types for the multi-channel timer.
// Holds the register map (channel offsets, STATUS address), CTRL bit
// positions, reset/write/interrupt polarities and the per-channel write
// request struct used between the decoder and the channel instances.
package timer_mc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;     // decoded low address bits
    localparam int unsigned CTRL_W = 4;     // implemented CTRL bits

    // Signal polarities
    localparam logic RST_ACTIVE = 1'b0;
    localparam logic WE_ACTIVE  = 1'b1;
    localparam logic INT_ACTIVE = 1'b1;

    // Per-channel register offsets (channel n lives at 0x10*n)
    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_COUNT    = 4'h4;
    localparam logic [3:0] OFF_VALUE    = 4'h8;
    localparam logic [3:0] OFF_PRESCALE = 4'hC;

    // Global pending status register
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 8'hF0;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_IE_BIT   = 1;
    localparam int unsigned CTRL_PEND_BIT = 2;
    localparam int unsigned CTRL_MODE_BIT = 3;

    // Decoded write request for one channel
    typedef struct packed {
        logic ctrl_we;
        logic value_we;
        logic prescale_we;
        logic clr_pend;
    } ch_wr_t;

    // Channel index field of a decoded address
    function automatic logic [3:0] addr_ch(input logic [ADDR_W-1:0] a);
        return a[7:4];
    endfunction

    // Register offset field of a decoded address
    function automatic logic [3:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[3:0];
    endfunction

endpackage

// File: rtl/timer_ch.sv
// One timer channel: prescaler, up-counter, compare and control/pending.
// Ports:
//   clk, rst      clock, async active-low reset
//   wr            decoded write strobes for this channel
//   wdata         write data
//   ctrl          CTRL readback {mode, pending, int_en, enable}
//   count         current counter value
//   value         compare value
//   prescale      prescaler reload value
//   irq           pending & int_en
module timer_ch
    import timer_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  ch_wr_t            wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  value,
    output logic [PRE_W-1:0]  prescale,
    output logic              irq
);

    logic             enable, int_en, mode, pending;
    logic [PRE_W-1:0] pre_cnt;

    logic             enable_nxt, int_en_nxt, mode_nxt, pending_nxt;
    logic [PRE_W-1:0] pre_cnt_nxt, prescale_nxt;
    logic [CNT_W-1:0] count_nxt, value_nxt;
    logic             tick, expire;

    // Next-state logic
    always_comb begin
        tick         = enable && (pre_cnt == prescale);
        expire       = tick && (count >= value);

        enable_nxt   = enable;
        int_en_nxt   = int_en;
        mode_nxt     = mode;
        value_nxt    = value;
        prescale_nxt = prescale;
        pre_cnt_nxt  = pre_cnt;
        count_nxt    = count;

        // Software CTRL write overrides the one-shot auto-clear of enable
        if (wr.ctrl_we) begin
            enable_nxt = wdata[CTRL_EN_BIT];
            int_en_nxt = wdata[CTRL_IE_BIT];
            mode_nxt   = wdata[CTRL_MODE_BIT];
        end else if (expire && !mode) begin
            enable_nxt = 1'b0;
        end

        // Hardware set beats a simultaneous software clear
        if (expire) begin
            pending_nxt = 1'b1;
        end else if (wr.clr_pend) begin
            pending_nxt = 1'b0;
        end else begin
            pending_nxt = pending;
        end

        if (wr.value_we) begin
            value_nxt = wdata[CNT_W-1:0];
        end
        if (wr.prescale_we) begin
            prescale_nxt = wdata[PRE_W-1:0];
        end

        // Disabled (or about to be) channels park both counters at zero
        if (!enable_nxt) begin
            pre_cnt_nxt = '0;
            count_nxt   = '0;
        end else if (enable) begin
            if (tick) begin
                pre_cnt_nxt = '0;
                count_nxt   = expire ? '0 : count + CNT_W'(1);
            end else begin
                pre_cnt_nxt = pre_cnt + PRE_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            enable   <= 1'b0;
            int_en   <= 1'b0;
            mode     <= 1'b0;
            pending  <= 1'b0;
            value    <= '0;
            prescale <= '0;
            pre_cnt  <= '0;
            count    <= '0;
        end else begin
            enable   <= enable_nxt;
            int_en   <= int_en_nxt;
            mode     <= mode_nxt;
            pending  <= pending_nxt;
            value    <= value_nxt;
            prescale <= prescale_nxt;
            pre_cnt  <= pre_cnt_nxt;
            count    <= count_nxt;
        end
    end

    // CTRL readback
    always_comb begin
        ctrl                = '0;
        ctrl[CTRL_EN_BIT]   = enable;
        ctrl[CTRL_IE_BIT]   = int_en;
        ctrl[CTRL_PEND_BIT] = pending;
        ctrl[CTRL_MODE_BIT] = mode;
    end

    assign irq = INT_ACTIVE & pending & int_en;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer top: address decode, read mux, interrupt reduction.
// Ports:
//   clk, rst      clock, async active-low reset
//   data_i        write data
//   addr_i        register address (low 8 bits decoded)
//   we_i          write strobe
//   data_o        combinational read data for addr_i
//   int_vec_o     per-channel interrupt (pending & int_en)
//   int_sig_o     OR of int_vec_o
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    output logic [DATA_W-1:0] data_o,
    output logic [NUM_CH-1:0] int_vec_o,
    output logic              int_sig_o
);

    logic [ADDR_W-1:0] a8;
    logic [3:0]        ch_sel, off;
    logic              is_status, wr_en;
    logic              unused_addr;

    logic [CTRL_W-1:0] ch_ctrl     [NUM_CH];
    logic [CNT_W-1:0]  ch_count    [NUM_CH];
    logic [CNT_W-1:0]  ch_value    [NUM_CH];
    logic [PRE_W-1:0]  ch_prescale [NUM_CH];
    logic [NUM_CH-1:0] pend_vec;

    assign a8          = addr_i[ADDR_W-1:0];
    assign unused_addr = ^addr_i[31:ADDR_W];
    assign ch_sel      = addr_ch(a8);
    assign off         = addr_off(a8);
    assign is_status   = (a8 == STATUS_ADDR);
    assign wr_en       = (we_i == WE_ACTIVE);

    // Per-channel write decode and instance
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ch_wr_t wr;
        logic   sel;

        assign sel            = (ch_sel == 4'(n));
        assign wr.ctrl_we     = wr_en && sel && (off == OFF_CTRL);
        assign wr.value_we    = wr_en && sel && (off == OFF_VALUE);
        assign wr.prescale_we = wr_en && sel && (off == OFF_PRESCALE);
        assign wr.clr_pend    = (wr.ctrl_we && data_i[CTRL_PEND_BIT])
                              || (wr_en && is_status && data_i[n]);

        timer_ch #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr),
            .wdata    (data_i),
            .ctrl     (ch_ctrl[n]),
            .count    (ch_count[n]),
            .value    (ch_value[n]),
            .prescale (ch_prescale[n]),
            .irq      (int_vec_o[n])
        );

        assign pend_vec[n] = ch_ctrl[n][CTRL_PEND_BIT];
    end

    // Read mux; unmapped channels/offsets read zero
    always_comb begin
        data_o = '0;
        if (is_status) begin
            data_o[NUM_CH-1:0] = pend_vec;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_sel == 4'(n)) begin
                case (off)
                    OFF_CTRL:     data_o = DATA_W'(ch_ctrl[n]);
                    OFF_COUNT:    data_o = DATA_W'(ch_count[n]);
                    OFF_VALUE:    data_o = DATA_W'(ch_value[n]);
                    OFF_PRESCALE: data_o = DATA_W'(ch_prescale[n]);
                    default:      ;
                endcase
            end
        end
    end

    assign int_sig_o = |int_vec_o;

endmodule

// File: tb/tb_timer_mc.sv
// Directed self-checking bench for timer_mc (NUM_CH=4, CNT_W=32, PRE_W=8).
module tb_timer_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i, addr_i, data_o;
    logic        we_i;
    logic [3:0]  int_vec_o;
    logic        int_sig_o;

    int n_checks = 0;
    int n_fail   = 0;

    timer_mc #(.NUM_CH(4), .CNT_W(32), .PRE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .data_o    (data_o),
        .int_vec_o (int_vec_o),
        .int_sig_o (int_sig_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a write for one clock edge; called at a falling edge, returns at the next one
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        check_eq(tag, data_o, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
        @(negedge clk);
        check_eq("rst_int_sig", 32'(int_sig_o), 0);
        chk_rd("rst_ctrl0", 32'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_rd("status_idle", 32'hF0, 0);

        // Register access masking and decode
        wr(32'h2C, 32'hFFFF_FFFF);
        chk_rd("prescale_mask", 32'h2C, 32'h0000_00FF);
        wr(32'h28, 32'hDEAD_BEEF);
        chk_rd("value_rw", 32'h28, 32'hDEAD_BEEF);
        wr(32'h24, 32'h0000_1234);
        chk_rd("count_ro", 32'h24, 0);
        wr(32'h50, 32'h0000_1234);
        chk_rd("ch5_read", 32'h50, 0);
        chk_rd("unmapped_off", 32'h2A, 0);

        // Ch0 one-shot, VALUE=5, PRESCALE=0
        wr(32'h08, 5);
        wr(32'h0C, 0);
        wr(32'h00, 32'h3);
        cyc(5);
        chk_rd("os_count5", 32'h04, 5);
        check_eq("os_no_int_yet", 32'(int_sig_o), 0);
        cyc(1);
        check_eq("os_int_sig", 32'(int_sig_o), 1);
        chk_rd("os_ctrl", 32'h00, 32'h6);
        chk_rd("os_count0", 32'h04, 0);
        wr(32'h00, 32'h4);
        check_eq("os_int_clr", 32'(int_sig_o), 0);
        chk_rd("os_ctrl_clr", 32'h00, 0);

        // Ch1 auto-reload, VALUE=3, PRESCALE=2
        wr(32'h18, 3);
        wr(32'h1C, 2);
        wr(32'h10, 32'hB);
        for (int k = 0; k < 12; k++) begin
            chk_rd($sformatf("ar_count_%0d", k), 32'h14, 32'(k / 3));
            cyc(1);
        end
        check_eq("ar_int_vec", 32'(int_vec_o), 32'h2);
        chk_rd("ar_count_wrap", 32'h14, 0);
        chk_rd("ar_ctrl", 32'h10, 32'hF);
        wr(32'hF0, 32'h2);
        chk_rd("ar_ctrl_clr", 32'h10, 32'hB);
        cyc(11);
        chk_rd("ar_second_expiry", 32'h10, 32'hF);
        wr(32'h10, 32'h4);
        chk_rd("ar_stopped", 32'h10, 0);

        // Ch2 expiry coinciding with STATUS clear
        wr(32'h28, 1);
        wr(32'h2C, 0);
        wr(32'h20, 32'h1);
        cyc(1);
        wr(32'hF0, 32'h4);
        chk_rd("hw_wins_status", 32'hF0, 32'h4);
        chk_rd("hw_wins_ctrl", 32'h20, 32'h4);
        wr(32'hF0, 32'h4);
        chk_rd("sw_clear", 32'hF0, 0);

        // Ch0 and ch3 expiring on the same edge
        wr(32'h08, 3);
        wr(32'h38, 2);
        wr(32'h3C, 0);
        wr(32'h00, 32'h3);
        wr(32'h30, 32'h3);
        cyc(2);
        check_eq("multi_before", 32'(int_vec_o), 0);
        cyc(1);
        check_eq("multi_int_vec", 32'(int_vec_o), 32'h9);
        chk_rd("multi_status", 32'hF0, 32'h9);
        wr(32'hF0, 32'h1);
        chk_rd("multi_status_clr0", 32'hF0, 32'h8);
        check_eq("multi_int_vec_clr0", 32'(int_vec_o), 32'h8);
        wr(32'hF0, 32'h8);

        // Ch0 VALUE lowered below COUNT while running
        wr(32'h08, 100);
        wr(32'h00, 32'hB);
        cyc(50);
        chk_rd("vchg_count50", 32'h04, 50);
        wr(32'h08, 1);
        chk_rd("vchg_count51", 32'h04, 51);
        chk_rd("vchg_not_yet", 32'hF0, 0);
        cyc(1);
        chk_rd("vchg_count0", 32'h04, 0);
        chk_rd("vchg_ctrl", 32'h00, 32'hF);
        cyc(1);
        chk_rd("vchg_count1", 32'h04, 1);

        // Asynchronous reset mid-count
        wr(32'h18, 1000);
        wr(32'h1C, 0);
        wr(32'h10, 32'h1);
        cyc(10);
        chk_rd("pre_rst_count", 32'h14, 10);
        check_eq("pre_rst_int_sig", 32'(int_sig_o), 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_int_vec", 32'(int_vec_o), 0);
        check_eq("rst_int_sig_async", 32'(int_sig_o), 0);
        chk_rd("rst_count", 32'h14, 0);
        chk_rd("rst_ctrl", 32'h00, 0);
        chk_rd("rst_0x50", 32'h50, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        chk_rd("post_rst_ctrl", 32'h00, 0);
        chk_rd("post_rst_count", 32'h14, 0);
        chk_rd("post_rst_status", 32'hF0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
